// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_unit
// Purpose  : RV32 ID-stage decode, ID/EX control register, stall/flush control
//            and MUL/DIV freeze sequencer (enabled by macro M_EXT_EN).
// Revision : 1.0  initial release
// ============================================================================
module pipe_ctrl_unit #(
  parameter int OPCODE_WIDTH   = 7,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MUL_LATENCY    = 3,
  parameter int DIV_LATENCY    = 32,
  parameter int CNT_WIDTH      = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [OPCODE_WIDTH-1:0]   id_opcode,
  input  logic [2:0]                id_funct3,
  input  logic [6:0]                id_funct7,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      branch_taken,
  output logic [2:0]                id_imm_type,
  output logic [1:0]                ex_alu_op,
  output logic [1:0]                ex_wb_sel,
  output logic                      ex_reg_w,
  output logic                      ex_alu_src1,
  output logic                      ex_alu_src2,
  output logic                      ex_mem_w,
  output logic                      ex_mem_r,
  output logic                      ex_branch,
  output logic                      ex_jump,
  output logic                      ex_csr_en,
  output logic                      ex_md_op,
  output logic [2:0]                ex_funct3,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic                      pc_stall,
  output logic                      if_id_stall,
  output logic                      if_id_flush,
  output logic                      md_start,
  output logic                      md_busy,
  output logic                      md_done,
  output logic                      illegal_instr
);

  localparam logic [OPCODE_WIDTH-1:0] OP_R     = OPCODE_WIDTH'(7'b0110011);
  localparam logic [OPCODE_WIDTH-1:0] OP_IALU  = OPCODE_WIDTH'(7'b0010011);
  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = OPCODE_WIDTH'(7'b0000011);
  localparam logic [OPCODE_WIDTH-1:0] OP_JALR  = OPCODE_WIDTH'(7'b1100111);
  localparam logic [OPCODE_WIDTH-1:0] OP_CSR   = OPCODE_WIDTH'(7'b1110011);
  localparam logic [OPCODE_WIDTH-1:0] OP_STORE = OPCODE_WIDTH'(7'b0100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_BR    = OPCODE_WIDTH'(7'b1100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_LUI   = OPCODE_WIDTH'(7'b0110111);
  localparam logic [OPCODE_WIDTH-1:0] OP_AUIPC = OPCODE_WIDTH'(7'b0010111);
  localparam logic [OPCODE_WIDTH-1:0] OP_JAL   = OPCODE_WIDTH'(7'b1101111);

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_BR  = 2'd1;
  localparam logic [1:0] ALU_R   = 2'd2;
  localparam logic [1:0] ALU_I   = 2'd3;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_PC4 = 2'd1;
  localparam logic [1:0] WB_MEM = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  if (MUL_LATENCY < 1 || DIV_LATENCY < 1 ||
      (1 << CNT_WIDTH) < MUL_LATENCY || (1 << CNT_WIDTH) < DIV_LATENCY) begin : g_param_check
    $error("pipe_ctrl_unit: latency parameters out of range");
  end

  typedef struct packed {
    logic [1:0]                alu_op;
    logic [1:0]                wb_sel;
    logic                      reg_w;
    logic                      src1;
    logic                      src2;
    logic                      mem_w;
    logic                      mem_r;
    logic                      branch;
    logic                      jump;
    logic                      csr_en;
    logic                      md_op;
    logic [2:0]                funct3;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } bundle_t;

  bundle_t dec, ex_d, ex_q;
  logic    dec_ill, rs1_used, rs2_used;
  logic    load_use, flush, md_stall;

  always_comb begin
    dec         = '0;
    id_imm_type = IMM_NONE;
    dec_ill     = 1'b0;
    rs1_used    = 1'b0;
    rs2_used    = 1'b0;
    case (id_opcode)
      OP_R: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        if (id_funct7 == 7'b0000000 ||
            (id_funct7 == 7'b0100000 && (id_funct3 == 3'b000 || id_funct3 == 3'b101))) begin
          dec.alu_op = ALU_R;
          dec.reg_w  = 1'b1;
        end
`ifdef M_EXT_EN
        else if (id_funct7 == 7'b0000001) begin
          dec.alu_op = ALU_R;
          dec.reg_w  = 1'b1;
          dec.md_op  = 1'b1;
        end
`endif
        else begin
          dec_ill = 1'b1;
        end
      end
      OP_IALU: begin
        rs1_used    = 1'b1;
        id_imm_type = IMM_I;
        // Shift-immediates carry their sub-opcode in the funct7 slot.
        if ((id_funct3 == 3'b001 && id_funct7 != 7'b0000000) ||
            (id_funct3 == 3'b101 && id_funct7 != 7'b0000000 && id_funct7 != 7'b0100000)) begin
          dec_ill = 1'b1;
        end else begin
          dec.alu_op = ALU_I;
          dec.reg_w  = 1'b1;
          dec.src2   = 1'b1;
        end
      end
      OP_LOAD: begin
        rs1_used    = 1'b1;
        id_imm_type = IMM_I;
        dec.wb_sel  = WB_MEM;
        dec.reg_w   = 1'b1;
        dec.src2    = 1'b1;
        dec.mem_r   = 1'b1;
      end
      OP_JALR: begin
        rs1_used    = 1'b1;
        id_imm_type = IMM_I;
        dec.wb_sel  = WB_PC4;
        dec.reg_w   = 1'b1;
        dec.src2    = 1'b1;
        dec.jump    = 1'b1;
      end
      OP_CSR: begin
        rs1_used    = 1'b1;
        id_imm_type = IMM_I;
        dec.reg_w   = 1'b1;
        dec.csr_en  = 1'b1;
      end
      OP_STORE: begin
        rs1_used    = 1'b1;
        rs2_used    = 1'b1;
        id_imm_type = IMM_S;
        dec.src2    = 1'b1;
        dec.mem_w   = 1'b1;
      end
      OP_BR: begin
        rs1_used    = 1'b1;
        rs2_used    = 1'b1;
        id_imm_type = IMM_B;
        dec.alu_op  = ALU_BR;
        dec.branch  = 1'b1;
      end
      OP_LUI: begin
        id_imm_type = IMM_U;
        dec.wb_sel  = WB_IMM;
        dec.reg_w   = 1'b1;
      end
      OP_AUIPC: begin
        id_imm_type = IMM_U;
        dec.reg_w   = 1'b1;
        dec.src1    = 1'b1;
        dec.src2    = 1'b1;
      end
      OP_JAL: begin
        id_imm_type = IMM_J;
        dec.wb_sel  = WB_PC4;
        dec.reg_w   = 1'b1;
        dec.src1    = 1'b1;
        dec.src2    = 1'b1;
        dec.jump    = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
    if (!dec_ill) begin
      dec.funct3 = id_funct3;
      dec.rd     = id_rd;
    end
  end

  assign illegal_instr = dec_ill;

  assign load_use = ex_q.mem_r && (ex_q.rd != '0) &&
                    ((rs1_used && ex_q.rd == id_rs1) || (rs2_used && ex_q.rd == id_rs2));
  assign flush       = branch_taken | ex_q.jump;
  assign pc_stall    = md_stall | (~flush & load_use);
  assign if_id_stall = pc_stall;
  assign if_id_flush = ~md_stall & flush;

  always_comb begin
    ex_d = dec;
    if (md_stall) begin
      ex_d = ex_q;
    end else if (flush || load_use) begin
      ex_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

`ifdef M_EXT_EN
  localparam logic [CNT_WIDTH-1:0] C_MUL_LAST = CNT_WIDTH'(MUL_LATENCY - 1);
  localparam logic [CNT_WIDTH-1:0] C_DIV_LAST = CNT_WIDTH'(DIV_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_t;

  md_state_t            state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 div_q, div_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
    end
  end

  // DONE always returns to IDLE so an md op still sitting in EX cannot retrigger.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    md_start = 1'b0;
    md_busy  = 1'b0;
    md_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ex_q.md_op) begin
          md_start = 1'b1;
          div_d    = ex_q.funct3[2];
          cnt_d    = '0;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        md_busy = 1'b1;
        cnt_d   = cnt_q + CNT_WIDTH'(1);
        if (cnt_q == (div_q ? C_DIV_LAST : C_MUL_LAST)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        md_done = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign md_stall = (state_q == ST_IDLE && ex_q.md_op) || state_q == ST_BUSY;
`else
  assign md_start = 1'b0;
  assign md_busy  = 1'b0;
  assign md_done  = 1'b0;
  assign md_stall = 1'b0;
`endif

  assign ex_alu_op   = ex_q.alu_op;
  assign ex_wb_sel   = ex_q.wb_sel;
  assign ex_reg_w    = ex_q.reg_w;
  assign ex_alu_src1 = ex_q.src1;
  assign ex_alu_src2 = ex_q.src2;
  assign ex_mem_w    = ex_q.mem_w;
  assign ex_mem_r    = ex_q.mem_r;
  assign ex_branch   = ex_q.branch;
  assign ex_jump     = ex_q.jump;
  assign ex_csr_en   = ex_q.csr_en;
  assign ex_md_op    = ex_q.md_op;
  assign ex_funct3   = ex_q.funct3;
  assign ex_rd       = ex_q.rd;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl_unit
// Purpose  : Scoreboard bench for pipe_ctrl_unit (decode, hazards, MUL/DIV).
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_ctrl_unit;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_CSR = 7'b1110011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] id_opcode;
  logic [2:0] id_funct3;
  logic [6:0] id_funct7;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       branch_taken;
  logic [2:0] id_imm_type;
  logic [1:0] ex_alu_op, ex_wb_sel;
  logic       ex_reg_w, ex_alu_src1, ex_alu_src2, ex_mem_w, ex_mem_r;
  logic       ex_branch, ex_jump, ex_csr_en, ex_md_op;
  logic [2:0] ex_funct3;
  logic [4:0] ex_rd;
  logic       pc_stall, if_id_stall, if_id_flush;
  logic       md_start, md_busy, md_done, illegal_instr;

  pipe_ctrl_unit #(
    .OPCODE_WIDTH  (7),
    .REG_ADDR_WIDTH(5),
    .MUL_LATENCY   (3),
    .DIV_LATENCY   (4),
    .CNT_WIDTH     (6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_opcode    (id_opcode),
    .id_funct3    (id_funct3),
    .id_funct7    (id_funct7),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .branch_taken (branch_taken),
    .id_imm_type  (id_imm_type),
    .ex_alu_op    (ex_alu_op),
    .ex_wb_sel    (ex_wb_sel),
    .ex_reg_w     (ex_reg_w),
    .ex_alu_src1  (ex_alu_src1),
    .ex_alu_src2  (ex_alu_src2),
    .ex_mem_w     (ex_mem_w),
    .ex_mem_r     (ex_mem_r),
    .ex_branch    (ex_branch),
    .ex_jump      (ex_jump),
    .ex_csr_en    (ex_csr_en),
    .ex_md_op     (ex_md_op),
    .ex_funct3    (ex_funct3),
    .ex_rd        (ex_rd),
    .pc_stall     (pc_stall),
    .if_id_stall  (if_id_stall),
    .if_id_flush  (if_id_flush),
    .md_start     (md_start),
    .md_busy      (md_busy),
    .md_done      (md_done),
    .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  logic [20:0] w_ex;
  logic [6:0]  w_flags;
  assign w_ex    = {ex_alu_op, ex_wb_sel, ex_reg_w, ex_alu_src1, ex_alu_src2, ex_mem_w,
                    ex_mem_r, ex_branch, ex_jump, ex_csr_en, ex_md_op, ex_funct3, ex_rd};
  assign w_flags = {pc_stall, if_id_stall, if_id_flush, md_start, md_busy, md_done, illegal_instr};

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [20:0] sb_q[$];
  logic [20:0] last_ex  = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference decode: control field = {alu,wb,reg_w,src1,src2,mem_w,mem_r,br,jump,csr,md}.
  function automatic void ref_dec(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [4:0] rd, output logic [20:0] b,
                                  output logic [2:0] imm, output logic ill);
    logic [12:0] c;
    c   = '0;
    imm = 3'd0;
    ill = 1'b0;
    case (opc)
      OP_R: begin
        if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))) c = 13'b10_00_1_0_0_0_0_0_0_0_0;
`ifdef M_EXT_EN
        else if (f7 == 7'h01) c = 13'b10_00_1_0_0_0_0_0_0_0_1;
`endif
        else ill = 1'b1;
      end
      OP_I: begin
        imm = 3'd1;
        if ((f3 == 3'b001 && f7 != 7'h00) || (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20)) ill = 1'b1;
        else c = 13'b11_00_1_0_1_0_0_0_0_0_0;
      end
      OP_LD:  begin imm = 3'd1; c = 13'b00_10_1_0_1_0_1_0_0_0_0; end
      OP_JR:  begin imm = 3'd1; c = 13'b00_01_1_0_1_0_0_0_1_0_0; end
      OP_CSR: begin imm = 3'd1; c = 13'b00_00_1_0_0_0_0_0_0_1_0; end
      OP_ST:  begin imm = 3'd2; c = 13'b00_00_0_0_1_1_0_0_0_0_0; end
      OP_BR:  begin imm = 3'd3; c = 13'b01_00_0_0_0_0_0_1_0_0_0; end
      OP_LUI: begin imm = 3'd4; c = 13'b00_11_1_0_0_0_0_0_0_0_0; end
      OP_AUI: begin imm = 3'd4; c = 13'b00_00_1_1_1_0_0_0_0_0_0; end
      OP_JAL: begin imm = 3'd5; c = 13'b00_01_1_1_1_0_0_0_1_0_0; end
      default: ill = 1'b1;
    endcase
    b = ill ? 21'd0 : {c, f3, rd};
  endfunction

  // kind: 0 = decoded bundle enters EX, 1 = zero bundle, 2 = ID/EX holds.
  // flags = {pc_stall, if_id_stall, if_id_flush, md_start, md_busy, md_done, illegal}.
  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic bt, input logic [6:0] flags, input int kind, input string tag);
    logic [20:0] b, exp;
    logic [2:0]  imm;
    logic        ill;
    @(negedge clk);
    id_opcode = opc; id_funct3 = f3; id_funct7 = f7;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; branch_taken = bt;
    #1;
    ref_dec(opc, f3, f7, rd, b, imm, ill);
    check_val({tag, "/flags"}, 32'(w_flags), 32'(flags));
    check_val({tag, "/imm"}, 32'(id_imm_type), 32'(imm));
    exp = (kind == 0) ? b : (kind == 1) ? 21'd0 : last_ex;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    exp = sb_q.pop_front();
    check_val({tag, "/ex"}, 32'(w_ex), 32'(exp));
    last_ex = exp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    id_opcode = '0; id_funct3 = '0; id_funct7 = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; branch_taken = 1'b0;
    repeat (2) @(negedge clk);
    check_val("reset/ex", 32'(w_ex), 32'd0);
    check_val("reset/flags", 32'(w_flags), 32'(7'b0000001));
    rst = 1'b0;

    drive(OP_R,   3'b000, 7'h00, 1, 2, 3, 0, 7'b0000000, 0, "add");
    drive(OP_I,   3'b000, 7'h00, 1, 0, 4, 0, 7'b0000000, 0, "addi");
    drive(OP_LD,  3'b010, 7'h00, 1, 0, 5, 0, 7'b0000000, 0, "lw5");
    drive(OP_R,   3'b000, 7'h00, 5, 1, 6, 0, 7'b1100000, 1, "lu_add");
    drive(OP_R,   3'b000, 7'h00, 5, 1, 6, 0, 7'b0000000, 0, "lu_retry");
    drive(OP_LD,  3'b010, 7'h00, 1, 0, 0, 0, 7'b0000000, 0, "lw0");
    drive(OP_R,   3'b000, 7'h00, 0, 1, 6, 0, 7'b0000000, 0, "lw0_add");
    drive(OP_LD,  3'b010, 7'h00, 1, 0, 5, 0, 7'b0000000, 0, "lw5b");
    drive(OP_LUI, 3'b101, 7'h00, 5, 5, 6, 0, 7'b0000000, 0, "lu_lui");
    drive(OP_LD,  3'b010, 7'h00, 1, 0, 5, 0, 7'b0000000, 0, "lw5c");
    drive(OP_ST,  3'b010, 7'h00, 2, 5, 0, 0, 7'b1100000, 1, "lu_sw");
    drive(OP_ST,  3'b010, 7'h00, 2, 5, 0, 0, 7'b0000000, 0, "sw");
    drive(OP_LD,  3'b010, 7'h00, 1, 0, 5, 0, 7'b0000000, 0, "lw5d");
    drive(OP_R,   3'b000, 7'h00, 5, 1, 6, 1, 7'b0010000, 1, "bt_lu");
    drive(OP_JAL, 3'b000, 7'h00, 0, 0, 1, 0, 7'b0000000, 0, "jal");
    drive(OP_I,   3'b000, 7'h00, 1, 0, 7, 0, 7'b0010000, 1, "jal_flush");
    drive(OP_BR,  3'b000, 7'h00, 1, 2, 0, 0, 7'b0000000, 0, "beq");
    drive(OP_AUI, 3'b000, 7'h00, 0, 0, 9, 0, 7'b0000000, 0, "auipc");
    drive(OP_JR,  3'b000, 7'h00, 1, 0, 1, 0, 7'b0000000, 0, "jalr");
    drive(OP_CSR, 3'b001, 7'h00, 1, 0, 2, 0, 7'b0010000, 1, "jalr_flush");
    drive(OP_CSR, 3'b001, 7'h00, 1, 0, 2, 0, 7'b0000000, 0, "csr");
    drive(7'h7F,  3'b000, 7'h00, 1, 2, 3, 0, 7'b0000001, 0, "bad_op");
    drive(OP_R,   3'b000, 7'h20, 1, 2, 3, 0, 7'b0000000, 0, "sub");
    drive(OP_R,   3'b001, 7'h20, 1, 2, 3, 0, 7'b0000001, 0, "bad_f7");
    drive(OP_I,   3'b001, 7'h20, 1, 0, 3, 0, 7'b0000001, 0, "bad_slli");

`ifdef M_EXT_EN
    drive(OP_R, 3'b100, 7'h01, 1, 2, 8, 0, 7'b0000000, 0, "div");
    drive(OP_R, 3'b000, 7'h00, 1, 2, 9, 0, 7'b1101000, 2, "div_start");
    for (int i = 0; i < 4; i++)
      drive(OP_R, 3'b000, 7'h00, 1, 2, 9, (i == 1), 7'b1100100, 2, "div_busy");
    drive(OP_R, 3'b000, 7'h01, 3, 4, 10, 0, 7'b0000010, 0, "div_done");
    drive(OP_R, 3'b000, 7'h00, 1, 2, 11, 0, 7'b1101000, 2, "mul_start");
    for (int i = 0; i < 3; i++)
      drive(OP_R, 3'b000, 7'h00, 1, 2, 11, 0, 7'b1100100, 2, "mul_busy");
    drive(OP_R, 3'b000, 7'h00, 1, 2, 11, 0, 7'b0000010, 0, "mul_done");
    drive(OP_R, 3'b000, 7'h00, 1, 2, 12, 0, 7'b0000000, 0, "post_md");

    drive(OP_R, 3'b110, 7'h01, 1, 2, 8, 0, 7'b0000000, 0, "rem");
    drive(OP_R, 3'b000, 7'h00, 1, 2, 9, 0, 7'b1101000, 2, "rem_start");
    drive(OP_R, 3'b000, 7'h00, 1, 2, 9, 0, 7'b1100100, 2, "rem_busy");
    drive(OP_R, 3'b000, 7'h00, 1, 2, 9, 0, 7'b1100100, 2, "rem_busy");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("rst_busy/ex", 32'(w_ex), 32'd0);
    check_val("rst_busy/md", 32'({pc_stall, md_start, md_busy, md_done}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_ex = '0;
    drive(OP_R, 3'b000, 7'h01, 1, 2, 13, 0, 7'b0000000, 0, "mul2");
    drive(OP_R, 3'b000, 7'h00, 1, 2, 14, 0, 7'b1101000, 2, "mul2_start");
    for (int i = 0; i < 3; i++)
      drive(OP_R, 3'b000, 7'h00, 1, 2, 14, 0, 7'b1100100, 2, "mul2_busy");
    drive(OP_R, 3'b000, 7'h00, 1, 2, 14, 0, 7'b0000010, 0, "mul2_done");
`else
    drive(OP_R, 3'b000, 7'h01, 1, 2, 8, 0, 7'b0000001, 0, "mul_noext");
    drive(OP_R, 3'b100, 7'h01, 1, 2, 8, 0, 7'b0000001, 0, "div_noext");
    for (int i = 0; i < 3; i++)
      drive(OP_R, 3'b000, 7'h00, 1, 2, 9, 0, 7'b0000000, 0, "noext_after");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
